// File: rtl/comp_sel_stream.sv
//------------------------------------------------------------------------------
// Module      : comp_sel_stream
// Description : N-way compressed-block selector/streamer. Picks the smallest
//               encoder output per block, streams it, drains the others.
//               Optional header beat enabled by macro COMP_SEL_HDR_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module comp_sel_stream #(
   parameter int N_CH      = 3,
   parameter int D_W       = 64,
   parameter int S_W       = 11,
   parameter int BLK_WORDS = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_CH*S_W-1:0]       size_i,
   input  logic [N_CH-1:0]           size_emp_i,
   input  logic [N_CH*D_W-1:0]       data_i,
   input  logic [N_CH-1:0]           data_emp_i,
   input  logic                      ready_i,
   output logic                      size_rd_o,
   output logic [N_CH-1:0]           data_rd_o,
   output logic [D_W-1:0]            data_o,
   output logic                      valid_o,
   output logic                      sop_o,
   output logic                      eop_o,
   output logic [$clog2(N_CH)-1:0]   sel_o,
   output logic                      busy_o,
   output logic                      err_o
);

   localparam int c_SEL_W    = $clog2(N_CH);
   localparam int c_CNT_W    = $clog2(BLK_WORDS + 1);
   localparam int c_MAX_BITS = BLK_WORDS * D_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEL    = 2'd1,
      ST_HDR    = 2'd2,
      ST_STREAM = 2'd3
   } state_t;

   state_t               r_state;
   logic [c_SEL_W-1:0]   r_sel;
   logic [c_CNT_W-1:0]   r_win_cnt;
   logic [c_CNT_W-1:0]   r_drain_cnt [N_CH];
   logic                 r_first;
   logic                 r_err;
`ifdef COMP_SEL_HDR_EN
   logic [S_W-1:0]       r_win_size;
   logic [D_W-1:0]       w_hdr;
`endif

   logic [c_SEL_W-1:0]   w_win;
   logic [S_W-1:0]       w_win_size;
   logic                 w_over;
   logic                 w_active;
   logic                 w_win_empty;
   logic [D_W-1:0]       w_win_data;
   logic                 w_beat;
   logic [c_CNT_W-1:0]   w_win_nxt;
   logic [c_CNT_W-1:0]   w_drain_nxt [N_CH];
   logic                 w_done;

   // Block length in words: at least one word, saturated at the raw block size.
   function automatic logic [c_CNT_W-1:0] f_words(input logic [S_W-1:0] s);
      int unsigned v;
      v = (32'(s) + 32'(D_W) - 32'd1) / 32'(D_W);
      if (v == 0) v = 1;
      if (v > 32'(BLK_WORDS)) v = 32'(BLK_WORDS);
      return c_CNT_W'(v);
   endfunction

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      w_win      = '0;
      w_win_size = size_i[S_W-1:0];
      w_over     = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (32'(size_i[k*S_W +: S_W]) > 32'(c_MAX_BITS)) w_over = 1'b1;
         if (size_i[k*S_W +: S_W] < w_win_size) begin
            w_win      = c_SEL_W'(k);
            w_win_size = size_i[k*S_W +: S_W];
         end
      end
   end

   always_comb begin
      w_active    = (r_state == ST_HDR) || (r_state == ST_STREAM);
      w_win_empty = 1'b1;
      w_win_data  = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (r_sel == c_SEL_W'(k)) begin
            w_win_empty = data_emp_i[k];
            w_win_data  = data_i[k*D_W +: D_W];
         end
      end
`ifdef COMP_SEL_HDR_EN
      w_hdr        = '0;
      w_hdr[23:16] = 8'(r_sel);
      w_hdr[15:0]  = 16'(r_win_size);
`endif
      valid_o = 1'b0;
      data_o  = '0;
      sop_o   = 1'b0;
      eop_o   = 1'b0;
      case (r_state)
         ST_STREAM: begin
            if (!w_win_empty && (r_win_cnt != '0)) begin
               valid_o = 1'b1;
               data_o  = w_win_data;
               sop_o   = r_first;
               eop_o   = (r_win_cnt == c_CNT_W'(1));
            end
         end
`ifdef COMP_SEL_HDR_EN
         ST_HDR: begin
            valid_o = 1'b1;
            data_o  = w_hdr;
            sop_o   = 1'b1;
         end
`endif
         default: ;
      endcase
      w_beat = valid_o & ready_i;

      // Losers drain regardless of downstream ready.
      data_rd_o = '0;
      w_win_nxt = r_win_cnt;
      w_done    = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
         w_drain_nxt[k] = r_drain_cnt[k];
         if (r_sel == c_SEL_W'(k)) begin
            if ((r_state == ST_STREAM) && w_beat) data_rd_o[k] = 1'b1;
         end else if (w_active && (r_drain_cnt[k] != '0) && !data_emp_i[k]) begin
            data_rd_o[k]   = 1'b1;
            w_drain_nxt[k] = r_drain_cnt[k] - c_CNT_W'(1);
         end
         if (w_drain_nxt[k] != '0) w_done = 1'b0;
      end
      if ((r_state == ST_STREAM) && w_beat) w_win_nxt = r_win_cnt - c_CNT_W'(1);
      if (w_win_nxt != '0) w_done = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_sel     <= '0;
         r_win_cnt <= '0;
         r_first   <= 1'b0;
         r_err     <= 1'b0;
         for (int k = 0; k < N_CH; k++) r_drain_cnt[k] <= '0;
`ifdef COMP_SEL_HDR_EN
         r_win_size <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (size_emp_i == '0) r_state <= ST_SEL;
            end
            ST_SEL: begin
               r_sel     <= w_win;
               r_win_cnt <= f_words(w_win_size);
               r_first   <= 1'b1;
               if (w_over) r_err <= 1'b1;
               for (int k = 0; k < N_CH; k++)
                  r_drain_cnt[k] <= (c_SEL_W'(k) == w_win) ? '0 : f_words(size_i[k*S_W +: S_W]);
`ifdef COMP_SEL_HDR_EN
               r_win_size <= w_win_size;
               r_state    <= ST_HDR;
`else
               r_state    <= ST_STREAM;
`endif
            end
`ifdef COMP_SEL_HDR_EN
            ST_HDR: begin
               r_first <= 1'b0;
               for (int k = 0; k < N_CH; k++) r_drain_cnt[k] <= w_drain_nxt[k];
               if (ready_i) r_state <= ST_STREAM;
            end
`endif
            ST_STREAM: begin
               r_win_cnt <= w_win_nxt;
               for (int k = 0; k < N_CH; k++) r_drain_cnt[k] <= w_drain_nxt[k];
               if (w_beat) r_first <= 1'b0;
               if (w_done) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign size_rd_o = (r_state == ST_SEL);
   assign busy_o    = (r_state != ST_IDLE);
   assign sel_o     = r_sel;
   assign err_o     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_comp_sel_stream.sv
//------------------------------------------------------------------------------
// Module      : tb_comp_sel_stream
// Description : Directed bench for comp_sel_stream with modelled size/data FIFOs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_comp_sel_stream;

   localparam int N_CH = 3, D_W = 64, S_W = 11, BLK_WORDS = 8;
`ifdef COMP_SEL_HDR_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [N_CH*S_W-1:0]   size_i = '0;
   logic [N_CH-1:0]       size_emp_i = '1;
   logic [N_CH*D_W-1:0]   data_i = '0;
   logic [N_CH-1:0]       data_emp_i = '1;
   logic                  ready_i = 1'b1;
   logic                  size_rd_o;
   logic [N_CH-1:0]       data_rd_o;
   logic [D_W-1:0]        data_o;
   logic                  valid_o, sop_o, eop_o, busy_o, err_o;
   logic [1:0]            sel_o;

   always #5 clk = ~clk;

   comp_sel_stream #(.N_CH(N_CH), .D_W(D_W), .S_W(S_W), .BLK_WORDS(BLK_WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .size_i(size_i), .size_emp_i(size_emp_i),
      .data_i(data_i), .data_emp_i(data_emp_i), .ready_i(ready_i),
      .size_rd_o(size_rd_o), .data_rd_o(data_rd_o), .data_o(data_o),
      .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o), .sel_o(sel_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   typedef struct { int s0, s1, s2, sel, w0, w1, w2, err; } vec_t;
   vec_t vt[8];

   logic [S_W-1:0] size_q [N_CH][$];
   logic [D_W-1:0] data_q [N_CH][$];
   logic [D_W-1:0] out_data[$];
   bit             out_sop[$];
   bit             out_eop[$];
   int             pops[N_CH];
   int             step_no, first_valid, n_chk, n_err;
   bit             inv_bad, underflow, saw_busy, last_busy, last_valid;
   logic [D_W-1:0] last_data;
   logic [N_CH-1:0] last_rd;

   function automatic logic [D_W-1:0] word(input int ch, input int idx);
      return {8'(ch), 8'hA5, 48'(idx)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic update_heads();
      for (int k = 0; k < N_CH; k++) begin
         size_emp_i[k] = (size_q[k].size() == 0);
         data_emp_i[k] = (data_q[k].size() == 0);
         size_i[k*S_W +: S_W] = size_emp_i[k] ? '0 : size_q[k][0];
         data_i[k*D_W +: D_W] = data_emp_i[k] ? '0 : data_q[k][0];
      end
   endtask

   task automatic clear_mon();
      out_data.delete(); out_sop.delete(); out_eop.delete();
      for (int k = 0; k < N_CH; k++) pops[k] = 0;
      step_no = 0; first_valid = -1;
      inv_bad = 0; underflow = 0; saw_busy = 0;
   endtask

   // One clock: observe at the falling edge, apply FIFO pops just after the rising edge.
   task automatic step();
      bit srd;
      @(negedge clk);
      step_no++;
      last_valid = valid_o; last_data = data_o; last_rd = data_rd_o; last_busy = busy_o;
      if (busy_o) saw_busy = 1;
      if (valid_o && first_valid < 0) first_valid = step_no;
      if (!valid_o && (data_o != '0 || sop_o || eop_o)) inv_bad = 1;
      if (valid_o && ready_i) begin
         out_data.push_back(data_o); out_sop.push_back(sop_o); out_eop.push_back(eop_o);
      end
      srd = size_rd_o;
      @(posedge clk); #1;
      for (int k = 0; k < N_CH; k++) begin
         if (last_rd[k]) begin
            if (data_q[k].size() == 0) underflow = 1;
            else begin void'(data_q[k].pop_front()); pops[k]++; end
         end
         if (srd) begin
            if (size_q[k].size() == 0) underflow = 1;
            else void'(size_q[k].pop_front());
         end
      end
      update_heads();
   endtask

   task automatic load(input int s0, s1, s2, w0, w1, w2);
      int ss[3], ww[3];
      ss = '{s0, s1, s2}; ww = '{w0, w1, w2};
      for (int k = 0; k < N_CH; k++) begin
         size_q[k].push_back(S_W'(ss[k]));
         for (int j = 0; j < ww[k]; j++) data_q[k].push_back(word(k, j));
      end
      update_heads();
      clear_mon();
   endtask

   task automatic run_to_idle(input string name, input int max);
      bit done;
      done = 0;
      for (int i = 0; i < max; i++) begin
         step();
         if (saw_busy && !last_busy) begin done = 1; break; end
      end
      chk({name, " completes"}, 64'(done), 64'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      chk("reset data_o", data_o, 64'd0);
      chk("reset ctrl", 64'({valid_o, sop_o, eop_o, sel_o, busy_o, err_o, size_rd_o, data_rd_o}), 64'd0);
      for (int k = 0; k < N_CH; k++) begin size_q[k].delete(); data_q[k].delete(); end
      update_heads();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic check_block(input string tag, input vec_t v);
      int ww[3], ss[3], nsop, neop, mism, nb;
      logic [D_W-1:0] d0;
      ww = '{v.w0, v.w1, v.w2}; ss = '{v.s0, v.s1, v.s2};
      nb = out_data.size();
      chk({tag, " sel_o"}, 64'(sel_o), 64'(v.sel));
      chk({tag, " beats"}, 64'(nb), 64'(ww[v.sel] + HDR));
      for (int k = 0; k < N_CH; k++)
         chk($sformatf("%s pops ch%0d", tag, k), 64'(pops[k]), 64'(ww[k]));
      chk({tag, " err_o"}, 64'(err_o), 64'(v.err));
      chk({tag, " first valid step"}, 64'(first_valid), 64'd3);
      chk({tag, " idle outputs zero, no underflow"}, 64'({inv_bad, underflow}), 64'd0);
      nsop = 0; neop = 0; mism = 0;
      for (int b = 0; b < nb; b++) begin
         nsop += int'(out_sop[b]); neop += int'(out_eop[b]);
         if (b >= HDR && out_data[b] !== word(v.sel, b - HDR)) mism++;
      end
      chk({tag, " payload mismatches"}, 64'(mism), 64'd0);
      chk({tag, " sop on beat0 only"}, 64'({nsop == 1, nb > 0 && out_sop[0]}), 64'd3);
      chk({tag, " eop on last only"}, 64'({neop == 1, nb > 0 && out_eop[nb-1]}), 64'd3);
`ifdef COMP_SEL_HDR_EN
      d0 = (nb > 0) ? out_data[0] : '1;
      chk({tag, " header"}, 64'(d0), 64'({8'(v.sel), 16'(ss[v.sel])}));
`else
      d0 = '0;
      chk({tag, " size fifo drained"}, 64'(size_q[0].size() + size_q[1].size() + size_q[2].size() + int'(d0)), 64'd0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok, bad_stable, bad_rd;
      int p2, nb0;
      n_chk = 0; n_err = 0;
      vt[0] = '{200, 130, 512, 1, 4, 3, 8, 0};
      vt[1] = '{128, 128, 600, 0, 2, 2, 8, 1};
      vt[2] = '{300, 300,   0, 2, 5, 5, 1, 0};
      vt[3] = '{ 64,  65,  63, 2, 1, 2, 1, 0};
      vt[4] = '{1000, 100, 200, 1, 8, 2, 4, 1};
      vt[5] = '{512, 513, 512, 0, 8, 8, 8, 1};
      vt[6] = '{ 70, 300, 300, 0, 2, 5, 5, 0};
      vt[7] = '{  5,   5,   5, 0, 1, 1, 1, 0};

      clear_mon();
      do_reset();

      for (int i = 0; i < 8; i++) begin
         do_reset();
         ready_i = 1'b1;
         load(vt[i].s0, vt[i].s1, vt[i].s2, vt[i].w0, vt[i].w1, vt[i].w2);
         run_to_idle($sformatf("v%0d", i), 200);
         check_block($sformatf("v%0d", i), vt[i]);
      end

      // Sticky error survives a clean block and clears only on reset.
      do_reset();
      load(1000, 100, 200, 8, 2, 4);
      run_to_idle("err blk1", 200);
      chk("err set", 64'(err_o), 64'd1);
      load(5, 5, 5, 1, 1, 1);
      run_to_idle("err blk2", 200);
      chk("err sticky", 64'(err_o), 64'd1);
      do_reset();
      chk("err cleared", 64'(err_o), 64'd0);

      // Backpressure after the second data beat.
      load(200, 130, 512, 4, 3, 8);
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (out_data.size() == HDR + 2) begin ok = 1; break; end
      end
      chk("bp reached beat1", 64'(ok), 64'd1);
      ready_i = 1'b0;
      p2 = pops[2]; bad_stable = 0; bad_rd = 0;
      repeat (5) begin
         step();
         if (!last_valid || last_data !== word(1, 2)) bad_stable = 1;
         if (last_rd[1]) bad_rd = 1;
      end
      chk("bp output stable", 64'(bad_stable), 64'd0);
      chk("bp no winner pop", 64'(bad_rd), 64'd0);
      chk("bp losers drain", 64'(pops[2] > p2), 64'd1);
      ready_i = 1'b1;
      run_to_idle("bp", 200);
      check_block("bp", vt[0]);

      // Winner FIFO runs dry mid-block.
      do_reset();
      load(200, 130, 512, 4, 1, 8);
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (out_data.size() == HDR + 1) begin ok = 1; break; end
      end
      chk("dry reached beat0", 64'(ok), 64'd1);
      nb0 = out_data.size(); bad_stable = 0;
      repeat (4) begin
         step();
         if (last_valid || !last_busy) bad_stable = 1;
      end
      chk("dry stall", 64'({bad_stable, out_data.size() != nb0}), 64'd0);
      data_q[1].push_back(word(1, 1)); data_q[1].push_back(word(1, 2));
      update_heads();
      run_to_idle("dry", 200);
      chk("dry beats", 64'(out_data.size()), 64'(3 + HDR));
      chk("dry pops ch1", 64'(pops[1]), 64'd3);

      // Asynchronous reset in the middle of the payload.
      do_reset();
      load(70, 300, 300, 2, 5, 5);
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (out_data.size() == HDR + 1) begin ok = 1; break; end
      end
      chk("midrst reached payload", 64'(ok), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst outputs", 64'({valid_o, sop_o, eop_o, sel_o, busy_o, err_o, size_rd_o, data_rd_o}), 64'd0);
      chk("midrst data_o", data_o, 64'd0);
      for (int k = 0; k < N_CH; k++) begin size_q[k].delete(); data_q[k].delete(); end
      update_heads();
      @(posedge clk); #1;
      rst_n = 1'b1;
      load(vt[3].s0, vt[3].s1, vt[3].s2, vt[3].w0, vt[3].w1, vt[3].w2);
      run_to_idle("after midrst", 200);
      check_block("after midrst", vt[3]);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
